// File: rtl/conv2d_stream_pkg.sv
// conv_pkg: shared types and sizing helpers for the conv2d_stream block.
package conv_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } conv_state_t;

    // Width needed to sum k*k full-precision dw x dw products without overflow.
    function automatic int acc_width(input int dw, input int k);
        return 2 * dw + $clog2(k * k);
    endfunction

    // Samples spanned by a k x k window sliding over a raster of width n.
    function automatic int win_len(input int n, input int k);
        return (k - 1) * n + k;
    endfunction

endpackage

// File: rtl/conv2d_stream_if.sv
// conv2d_stream_if: activation input stream and convolution result stream.
interface conv2d_stream_if #(
    parameter int DW = 16,
    parameter int OW = 32
);
    logic                 act_valid;
    logic signed [DW-1:0] activation;
    logic signed [OW-1:0] conv_op;
    logic                 valid_conv;
    logic                 end_conv;

    modport master (
        output act_valid, activation,
        input  conv_op, valid_conv, end_conv
    );

    modport slave (
        input  act_valid, activation,
        output conv_op, valid_conv, end_conv
    );
endinterface

// File: rtl/conv2d_stream_adder_tree.sv
// conv_adder_tree: sums NP signed products in a pairwise tree and registers
// the result. TW may be narrower than the products when the caller only needs
// the wrapped low bits of the sum.
module conv_adder_tree #(
    parameter int NP = 9,
    parameter int PW = 32,
    parameter int TW = 36
) (
    input  logic                 clk,
    input  logic                 global_rst_n,
    input  logic                 en,
    input  logic signed [PW-1:0] prod [NP],
    output logic signed [TW-1:0] sum
);

    logic signed [TW-1:0] node [NP];

    // Pairwise reduction; node[0] ends up holding the total.
    always_comb begin
        for (int i = 0; i < NP; i++) begin
            node[i] = TW'(prod[i]);
        end
        for (int step = 1; step < NP; step = step * 2) begin
            for (int i = 0; i + step < NP; i = i + 2 * step) begin
                node[i] = node[i] + node[i + step];
            end
        end
    end

    // Result register; holds the last valid sum between windows.
    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            sum <= '0;
        end else if (en) begin
            sum <= node[0];
        end
    end

endmodule

// File: rtl/conv2d_stream.sv
// conv2d_stream: streaming K x K 2-D convolution (stride S) over N x N raster
// frames. Two-stage pipeline: registered products, then registered tree sum.
// Build macro CONV_SAT_EN: saturate the result to OW bits instead of wrapping.
//
// state  | meaning
// IDLE   | next accepted pixel is (0,0) of a new frame
// ACTIVE | frame in progress, row/col hold the next pixel position
module conv2d_stream
    import conv_pkg::*;
#(
    parameter int N  = 4,
    parameter int K  = 3,
    parameter int S  = 1,
    parameter int DW = 16,
    parameter int OW = 32
) (
    input  logic              clk,
    input  logic              global_rst_n,
    input  logic              ce,
    input  logic [K*K*DW-1:0] weight1,
    conv2d_stream_if.slave    bus
);

    localparam int KK = K * K;
    localparam int PW = 2 * DW;
    localparam int AW = acc_width(DW, K);
    localparam int WL = win_len(N, K);
    localparam int HL = (WL > 1) ? WL - 1 : 1;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
`ifdef CONV_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    // When wrapping, only the low OW bits of the sum matter, so the tree is
    // built that narrow; saturation needs the full accumulator.
    localparam int TW = (!SAT && OW < AW) ? OW : AW;

    if (K < 1) begin : g_bad_k
        $error("conv2d_stream: K must be at least 1");
    end else if (N < K) begin : g_bad_n
        $error("conv2d_stream: N must be at least K");
    end else if (S < 1) begin : g_bad_s
        $error("conv2d_stream: S must be at least 1");
    end else if ((N - K) % S != 0) begin : g_bad_stride
        $error("conv2d_stream: (N-K) must be a multiple of S");
    end

    conv_state_t          state;
    logic [CW-1:0]        row, col;
    logic [CW-1:0]        pos_row, pos_col;
    logic                 accept, row_hit, col_hit, win_hit, last_pix;
    logic signed [DW-1:0] hist [HL];
    logic signed [PW-1:0] prod_next [KK];
    logic signed [PW-1:0] prod_q [KK];
    logic                 v1, e1, valid_q, end_q;
    logic signed [TW-1:0] acc;

    assign accept   = ce & bus.act_valid;
    assign pos_row  = (state == IDLE) ? '0 : row;
    assign pos_col  = (state == IDLE) ? '0 : col;
    assign row_hit  = (32'(pos_row) >= 32'(K - 1)) &&
                      (((32'(pos_row) - 32'(K - 1)) % 32'(S)) == 32'd0);
    assign col_hit  = (32'(pos_col) >= 32'(K - 1)) &&
                      (((32'(pos_col) - 32'(K - 1)) % 32'(S)) == 32'd0);
    assign win_hit  = accept & row_hit & col_hit;
    assign last_pix = (pos_row == CW'(N - 1)) && (pos_col == CW'(N - 1));

    // Frame position tracking; the last pixel of a frame returns to IDLE so
    // the next frame starts without a gap.
    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            state <= IDLE;
            row   <= '0;
            col   <= '0;
        end else if (accept) begin
            if (last_pix) begin
                state <= IDLE;
                row   <= '0;
                col   <= '0;
            end else begin
                state <= ACTIVE;
                if (pos_col == CW'(N - 1)) begin
                    col <= '0;
                    row <= pos_row + CW'(1);
                end else begin
                    col <= pos_col + CW'(1);
                    row <= pos_row;
                end
            end
        end
    end

    // Sample history; together with the incoming sample it forms the window.
    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            for (int i = 0; i < HL; i++) begin
                hist[i] <= '0;
            end
        end else if (accept) begin
            hist[0] <= bus.activation;
            for (int i = 1; i < HL; i++) begin
                hist[i] <= hist[i - 1];
            end
        end
    end

    // Window tap (r,c) sits (K-1-r) rows and (K-1-c) pixels behind the newest.
    for (genvar r = 0; r < K; r++) begin : g_row
        for (genvar c = 0; c < K; c++) begin : g_col
            localparam int AGE = (K - 1 - r) * N + (K - 1 - c);
            logic signed [DW-1:0] pix;
            logic signed [DW-1:0] wgt;
            if (AGE == 0) begin : g_new
                assign pix = bus.activation;
            end else begin : g_old
                assign pix = hist[AGE - 1];
            end
            assign wgt = weight1[(r * K + c) * DW +: DW];
            assign prod_next[r * K + c] = PW'(pix) * PW'(wgt);
        end
    end

    // Stage 1: capture products of a completed window.
    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            v1 <= 1'b0;
            e1 <= 1'b0;
            for (int i = 0; i < KK; i++) begin
                prod_q[i] <= '0;
            end
        end else if (ce) begin
            v1 <= win_hit;
            e1 <= win_hit & last_pix;
            if (win_hit) begin
                prod_q <= prod_next;
            end
        end
    end

    conv_adder_tree #(
        .NP (KK),
        .PW (PW),
        .TW (TW)
    ) u_adder_tree (
        .clk          (clk),
        .global_rst_n (global_rst_n),
        .en           (ce & v1),
        .prod         (prod_q),
        .sum          (acc)
    );

    // Stage 2 flags, aligned with the registered sum.
    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            valid_q <= 1'b0;
            end_q   <= 1'b0;
        end else if (ce) begin
            valid_q <= v1;
            end_q   <= e1;
        end
    end

    assign bus.valid_conv = valid_q;
    assign bus.end_conv   = end_q;

    if (TW <= OW) begin : g_extend
        assign bus.conv_op = OW'(acc);
    end else begin : g_saturate
        localparam logic signed [TW-1:0] MAX_V = {{(TW-OW+1){1'b0}}, {(OW-1){1'b1}}};
        localparam logic signed [TW-1:0] MIN_V = {{(TW-OW+1){1'b1}}, {(OW-1){1'b0}}};
        assign bus.conv_op = (acc > MAX_V) ? MAX_V[OW-1:0] :
                             (acc < MIN_V) ? MIN_V[OW-1:0] : acc[OW-1:0];
    end

endmodule

// File: tb/tb_conv2d_stream.sv
// tb_conv2d_stream: two conv2d_stream instances (4x4 stride 1 / 32-bit result,
// 5x5 stride 2 / 16-bit result) share one stimulus stream and are compared to
// a frame-array reference model. Honours CONV_SAT_EN like the design.
module tb_conv2d_stream;

    localparam int DW  = 16;
    localparam int K   = 3;
    localparam int NA  = 4;
    localparam int SA  = 1;
    localparam int OWA = 32;
    localparam int NB  = 5;
    localparam int SB  = 2;
    localparam int OWB = 16;

    typedef struct {
        int     inst;
        longint val;
        bit     last;
        int     due;
    } exp_t;

    typedef struct {
        int     inst;
        longint val;
        bit     last;
    } cap_t;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 ce;
    logic                 av;
    logic signed [DW-1:0] act;
    logic [K*K*DW-1:0]    weight1;

    int     n_checks = 0;
    int     n_errors = 0;
    int     ce_idx   = 0;
    int     w_s [K*K];
    int     frame [2][NB*NB];
    int     pos [2];
    int     n_of [2] = '{NA, NB};
    int     s_of [2] = '{SA, SB};
    int     ow_of [2] = '{OWA, OWB};
    exp_t   exp_q [$];
    cap_t   cap_q [$];
    bit     ov [2];
    bit     oe [2];
    longint oo [2];

    conv2d_stream_if #(.DW(DW), .OW(OWA)) bus_a ();
    conv2d_stream_if #(.DW(DW), .OW(OWB)) bus_b ();

    assign bus_a.act_valid  = av;
    assign bus_a.activation = act;
    assign bus_b.act_valid  = av;
    assign bus_b.activation = act;

    conv2d_stream #(.N(NA), .K(K), .S(SA), .DW(DW), .OW(OWA)) dut_a (
        .clk          (clk),
        .global_rst_n (rst_n),
        .ce           (ce),
        .weight1      (weight1),
        .bus          (bus_a)
    );

    conv2d_stream #(.N(NB), .K(K), .S(SB), .DW(DW), .OW(OWB)) dut_b (
        .clk          (clk),
        .global_rst_n (rst_n),
        .ce           (ce),
        .weight1      (weight1),
        .bus          (bus_b)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Result as seen at the output port: saturated or wrapped to ow bits.
    function automatic longint fit(input longint v, input int ow);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (ow - 1)) - 1;
        lo = -(longint'(1) <<< (ow - 1));
`ifdef CONV_SAT_EN
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
`else
        if (hi < lo) return 0;
        return (v <<< (64 - ow)) >>> (64 - ow);
`endif
    endfunction

    // Dot product of the kernel with the window whose bottom-right pixel is (row,col).
    function automatic longint ref_window(input int i, input int row, input int col);
        longint sum = 0;
        int n = n_of[i];
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                sum += longint'(w_s[r*K + c]) *
                       longint'(frame[i][(row - K + 1 + r) * n + (col - K + 1 + c)]);
            end
        end
        return fit(sum, ow_of[i]);
    endfunction

    task automatic model_accept(input int i, input int a);
        int n, s, row, col;
        exp_t e;
        n   = n_of[i];
        s   = s_of[i];
        row = pos[i] / n;
        col = pos[i] % n;
        frame[i][pos[i]] = a;
        if (row >= K - 1 && col >= K - 1 && (row - K + 1) % s == 0 && (col - K + 1) % s == 0) begin
            e.inst = i;
            e.val  = ref_window(i, row, col);
            e.last = (row - K + 1 == n - K) && (col - K + 1 == n - K);
            e.due  = ce_idx + 2;
            exp_q.push_back(e);
        end
        pos[i] = (pos[i] + 1) % (n * n);
    endtask

    function automatic int find_front(input int i);
        foreach (exp_q[j]) begin
            if (exp_q[j].inst == i) return j;
        end
        return -1;
    endfunction

    // Monitor and reference model, sampled mid-cycle.
    always @(negedge clk) begin
        int j;
        cap_t cp;
        ov[0] = bus_a.valid_conv; oe[0] = bus_a.end_conv; oo[0] = longint'(bus_a.conv_op);
        ov[1] = bus_b.valid_conv; oe[1] = bus_b.end_conv; oo[1] = longint'(bus_b.conv_op);
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                check_val($sformatf("rst_valid%0d", i), longint'(ov[i]), 0);
                check_val($sformatf("rst_end%0d", i), longint'(oe[i]), 0);
                check_val($sformatf("rst_op%0d", i), oo[i], 0);
            end
            exp_q.delete();
            pos[0] = 0;
            pos[1] = 0;
        end else if (ce) begin
            ce_idx++;
            for (int i = 0; i < 2; i++) begin
                j = find_front(i);
                if (ov[i]) begin
                    if (j < 0) begin
                        check_val($sformatf("spurious_valid%0d", i), 1, 0);
                    end else begin
                        check_val($sformatf("op%0d", i), oo[i], exp_q[j].val);
                        check_val($sformatf("end%0d", i), longint'(oe[i]), longint'(exp_q[j].last));
                        check_val($sformatf("latency%0d", i), ce_idx, exp_q[j].due);
                        exp_q.delete(j);
                    end
                    cp.inst = i;
                    cp.val  = oo[i];
                    cp.last = oe[i];
                    cap_q.push_back(cp);
                end else begin
                    check_val($sformatf("end_idle%0d", i), longint'(oe[i]), 0);
                    if (j >= 0 && exp_q[j].due <= ce_idx) begin
                        check_val($sformatf("missing_valid%0d", i), 0, 1);
                        exp_q.delete(j);
                    end
                end
            end
            if (av) begin
                model_accept(0, int'(act));
                model_accept(1, int'(act));
            end
        end
    end

    task automatic drive(input bit c, input bit v, input int a);
        @(posedge clk);
        #1;
        ce  = c;
        av  = v;
        act = DW'(a);
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) drive(1'b1, 1'b0, 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        ce    = 1'b0;
        av    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cap_q.delete();
    endtask

    task automatic set_weights(input bit rnd, input int val);
        for (int i = 0; i < K*K; i++) begin
            w_s[i] = rnd ? (int'($urandom_range(0, 65535)) - 32768) : val;
            weight1[i*DW +: DW] = DW'(w_s[i]);
        end
    endtask

    // Fixed-value check of one frame's four results from instance i.
    task automatic check_frame(input string tag, input int i,
                               input longint e0, input longint e1,
                               input longint e2, input longint e3);
        longint vals [$];
        bit     ends [$];
        longint ev [4];
        ev = '{e0, e1, e2, e3};
        foreach (cap_q[j]) begin
            if (cap_q[j].inst == i) begin
                vals.push_back(cap_q[j].val);
                ends.push_back(cap_q[j].last);
            end
        end
        check_val($sformatf("%s_count%0d", tag, i), vals.size(), 4);
        if (vals.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                check_val($sformatf("%s_val%0d_%0d", tag, i, k), vals[k], ev[k]);
            end
            check_val($sformatf("%s_end%0d", tag, i), longint'(ends[3]), 1);
            check_val($sformatf("%s_early_end%0d", tag, i), longint'(ends[0] | ends[1] | ends[2]), 0);
        end
    endtask

    task automatic ramp_frame(input bit gaps, input int ce_gap_after);
        for (int a = 0; a < NB*NB; a++) begin
            drive(1'b1, 1'b1, a);
            if (gaps) drive(1'b1, 1'b0, 0);
            if (a == ce_gap_after) begin
                for (int g = 0; g < 5; g++) drive(1'b0, 1'b1, 999);
            end
        end
        idle(6);
    endtask

    initial begin
        longint sat_a, sat_b;
        rst_n = 1'b1;
        ce    = 1'b0;
        av    = 1'b0;
        act   = '0;
        set_weights(1'b0, 1);
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Ramp 0..24 with unit weights.
        ramp_frame(1'b0, -1);
        check_frame("ramp", 0, 45, 54, 81, 90);
        check_frame("ramp", 1, 54, 72, 144, 162);

        // Reset in the middle of a frame, then a full frame.
        for (int a = 0; a < 7; a++) drive(1'b1, 1'b1, a);
        do_reset();
        ramp_frame(1'b0, -1);
        check_frame("midrst", 0, 45, 54, 81, 90);
        check_frame("midrst", 1, 54, 72, 144, 162);

        // act_valid low every other cycle.
        do_reset();
        ramp_frame(1'b1, -1);
        check_frame("gaps", 0, 45, 54, 81, 90);
        check_frame("gaps", 1, 54, 72, 144, 162);

        // Clock enable low for 5 cycles after sample 10.
        do_reset();
        ramp_frame(1'b0, 10);
        check_frame("ce_hold", 0, 45, 54, 81, 90);
        check_frame("ce_hold", 1, 54, 72, 144, 162);

        // Full-scale weights and activations.
        do_reset();
        set_weights(1'b0, 32767);
        for (int a = 0; a < NB*NB; a++) drive(1'b1, 1'b1, 32767);
        idle(6);
`ifdef CONV_SAT_EN
        sat_a = 64'sh7FFFFFFF;
        sat_b = 64'sh7FFF;
`else
        sat_a = 64'sh3FF70009;
        sat_b = 64'sh0009;
`endif
        check_frame("fullscale", 0, sat_a, sat_a, sat_a, sat_a);
        check_frame("fullscale", 1, sat_b, sat_b, sat_b, sat_b);

        // Randomized stream with random weights, ce and act_valid.
        do_reset();
        set_weights(1'b1, 0);
        for (int t = 0; t < 800; t++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, int'($urandom_range(0, 65535)));
        end
        idle(8);
        check_val("drain", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/conv2d_stream.md
CONV2D_STREAM -- requirements
Module: conv2d_stream

Interface
REQ-001 SHALL have parameter N, default 4: square input frame width/height in pixels (N >= K).
REQ-002 SHALL have parameter K, default 3: square kernel size (K >= 1).
REQ-003 SHALL have parameter S, default 1: stride in both dimensions; (N-K) % S != 0 SHALL be an elaboration error.
REQ-004 SHALL have parameter DW, default 16: signed activation/weight width.
REQ-005 SHALL have parameter OW, default 32: signed conv_op width.
REQ-006 SHALL have port clk, input, 1: single clock, rising edge.
REQ-007 SHALL have port global_rst_n, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have port ce, input, 1: clock enable; low freezes all state.
REQ-009 SHALL have port act_valid, input, 1: activation sample present this cycle.
REQ-010 SHALL have port activation, input, DW: signed pixel, raster order.
REQ-011 SHALL have port weight1, input, K*K*DW: kernel; slice i = w(r,c), i = r*K+c, slice 0 at LSBs.
REQ-012 SHALL have port conv_op, output, OW: signed convolution result.
REQ-013 SHALL have port valid_conv, output, 1: conv_op valid this cycle.
REQ-014 SHALL have port end_conv, output, 1: one-cycle pulse with last output of a frame.

Function
REQ-015 Sample accepted only when ce=1 and act_valid=1; all other cycles accept nothing.
REQ-016 Window store: shift register of (K-1)*N+K samples; shifts on acceptance only.
REQ-017 Row/col counters (0..N-1) advance per accepted sample; after (N-1,N-1), wrap to (0,0): next frame without idle cycle.
REQ-018 FSM IDLE -> ACTIVE on first accepted sample; ACTIVE -> IDLE on acceptance of pixel (N-1,N-1); IDLE accepts immediately.
REQ-019 Window valid when accepted pixel has row>=K-1, col>=K-1, (row-K+1)%S==0, (col-K+1)%S==0; ((N-K)/S+1)^2 outputs per frame.
REQ-020 Window pixel (r,c) multiplies w(r,c); r=0 oldest row, c=0 leftmost column.
REQ-021 Arithmetic signed; products 2*DW bits; sum in accumulator 2*DW+ceil(log2(K*K)) bits, no overflow.
REQ-022 Pipeline: stage 1 registers K*K products, stage 2 registers adder-tree sum; valid_conv high exactly 2 ce-high cycles after the completing sample.
REQ-023 Pipeline advances on every ce-high cycle, including cycles with act_valid=0.
REQ-024 end_conv high in the same cycle as valid_conv for window at top-left (N-K,N-K).
REQ-025 ce low: counters, window, pipeline and outputs hold values; valid_conv/end_conv held, not repeated on resume.
REQ-026 weight1 sampled at stage 1; caller holds it stable for a frame.

Reset
REQ-027 global_rst_n low: counters 0, FSM IDLE, window and pipeline cleared, conv_op=0, valid_conv=0, end_conv=0, independent of clk and ce.
REQ-028 Reset mid-frame discards partial frame and in-flight results; first accepted sample after release is pixel (0,0).

Configuration
REQ-029 Macro CONV_SAT_EN defined: accumulator saturated to signed OW range (max 2^(OW-1)-1, min -2^(OW-1)).
REQ-030 CONV_SAT_EN undefined: conv_op = low OW bits of accumulator (two's-complement wrap).

Structure
REQ-031 Package conv_pkg SHALL hold FSM state typedef (IDLE, ACTIVE), accumulator-width and window-length functions.
REQ-032 Sub-module conv_adder_tree (K*K signed products -> registered sum) SHALL be instantiated once.

Verification
REQ-033 N=4,K=3,S=1, all weights 1, activations 0..15, act_valid=1 -> conv_op 45,54,81,90; end_conv with 90.
REQ-034 N=5,K=3,S=2, all weights 1, activations 0..24 -> conv_op 54,72,144,162; end_conv with 162.
REQ-035 REQ-033 stimulus with act_valid low every other cycle -> same four values, each 2 cycles after completing sample.
REQ-036 DW=16,OW=16, weights and activations 0x7FFF -> with CONV_SAT_EN conv_op 0x7FFF; without 0x0009.
REQ-037 REQ-033 stimulus, global_rst_n low after 7 samples, then full frame -> no output before reset release, then 45,54,81,90.
REQ-038 ce low 5 cycles between samples 10 and 11 of REQ-033 -> outputs unchanged, valid_conv delayed 5 cycles, no duplicate.
